peripheral_dbg_pu_riscv_ahb_slave: RTL and testbench
====================================================

Name: peripheral_dbg_pu_riscv_ahb_slave

Overview:
AHB-Lite responder (slave) that terminates transfers issued by the debug unit's AHB master. It backs a small word-addressed scratch RAM and returns OKAY or ERROR responses, with an optional programmable number of wait states. The block is used as a debug-visible memory and as the standard bus target in debug-path testbenches.

Parameters:
ADDR_WIDTH, 32, HADDR width.
DATA_WIDTH, 32, HWDATA/HRDATA width; legal values are 32 or 64.
MEM_DEPTH, 256, RAM depth in DATA_WIDTH words; must be a power of two.
BASE_ADDR, 'h0, byte address of RAM word 0.
WAIT_STATES, 0, wait cycles inserted per transfer (0..15); used only with the optional feature.

Ports:
HCLK  in  1  bus clock; the only clock.
HRESETn  in  1  reset; asynchronous assert, active low.
HSEL  in  1  slave select.
HADDR  in  ADDR_WIDTH  byte address.
HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
HRDATA  out  DATA_WIDTH  read data.
HWRITE  in  1  1 = write.
HSIZE  in  3  transfer size.
HBURST  in  3  ignored; every beat is treated as an independent transfer.
HPROT  in  4  ignored.
HTRANS  in  2  transfer type.
HMASTLOCK  in  1  ignored.
HREADY  in  1  bus-level ready (previous transfer complete).
HREADYOUT  out  1  this slave's ready.
HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset values: HREADYOUT = 1, HRESP = 0, HRDATA = 0, FSM in IDLE, all address-phase registers cleared. RAM contents are not reset.
- Address phase is accepted when HSEL & HREADY & HTRANS[1] are all 1 (NONSEQ or SEQ).
  - On acceptance, register addr, write, size and a valid flag.
  - IDLE and BUSY transfers get a zero-wait OKAY.
- Error conditions, evaluated at acceptance:
  - address outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8);
  - HSIZE wider than DATA_WIDTH;
  - address misaligned for HSIZE.
  - An erroring write must not modify the RAM.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on an accepted transfer, go to ERR1 if it errors; otherwise go to WAIT if the wait count is nonzero; otherwise stay in IDLE and complete with zero wait.
  - WAIT: HREADYOUT = 0, HRESP = 0. A down-counter is loaded with WAIT_STATES; when it reaches 1, return to IDLE.
  - ERR1: HREADYOUT = 0, HRESP = 1. Always go to ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1. Return to IDLE; a new address phase accepted in this cycle is honoured.
- Writes:
  - Byte lanes come from addr[log2(DATA_WIDTH/8)-1:0] and size, little-endian.
  - The RAM is written at the HCLK edge that ends the data phase (HREADYOUT = 1 with OKAY).
- Reads:
  - HRDATA is the full RAM word addressed by the registered address, driven during the data phase.
  - A read that immediately follows a write to the same word returns the new data.
  - HRDATA outside a read data phase is don't-care and is held at its last value.
- An accepted transfer while HREADYOUT = 0 cannot occur, because HREADY is low. The slave does not check for it.
- Reset mid-transfer returns all outputs to reset values immediately and discards any pending write.

Optional Feature:
PERIPHERAL_DBG_AHB_SLAVE_WAIT_EN
- Defined: every OKAY transfer takes WAIT_STATES extra cycles with HREADYOUT = 0 before completion.
- Undefined: the WAIT state and counter are not compiled. All OKAY transfers are zero-wait, and WAIT_STATES is ignored.

Decomposition:
- Shared package peripheral_dbg_pu_riscv_pkg holds:
  - the HTRANS_*, HSIZE_* and HRESP encodings;
  - the slave FSM state enum;
  - a function returning byte enables from (size, addr low bits, DATA_WIDTH).
- One sub-module: peripheral_dbg_pu_riscv_ahb_slave_ram, a single-port RAM with per-byte write enables and a combinational read. It is replaceable by a technology macro.

Test Plan:
- Reset, then word write of 0xDEADBEEF to BASE_ADDR+4, then word read of the same address -> HRDATA = 0xDEADBEEF, HRESP = 0, zero wait, no idle between the write and read phases.
- Byte write of 0xA5 to BASE_ADDR+6 over word 0x11223344 at +4 -> reading word +4 returns 0x11A53344 (little-endian lanes).
- Word read at BASE_ADDR + MEM_DEPTH*4 -> ERR1 gives HREADYOUT = 0/HRESP = 1, then ERR2 gives HREADYOUT = 1/HRESP = 1; a following write there leaves the RAM unchanged.
- Halfword access at BASE_ADDR+1 (misaligned) -> two-cycle ERROR response; a subsequent aligned access returns OKAY.
- With the macro defined and WAIT_STATES = 3: a read takes exactly 3 cycles with HREADYOUT = 0, then data is valid with HREADYOUT = 1.
- Assert HRESETn low during a WAIT-state write -> HREADYOUT = 1 and HRESP = 0 immediately, and the target word is unchanged.

Source files
------------

// File: rtl/peripheral_dbg_pu_riscv_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and a byte-enable helper
// for the debug-unit bus slave.
package peripheral_dbg_pu_riscv_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } slave_state_e;

    // Little-endian lane mask; bit i enables byte lane i of the data bus.
    function automatic logic [7:0] byte_en(input logic [2:0] size,
                                           input logic [2:0] addr_lo,
                                           input int         data_width);
        logic [15:0] m;
        logic [2:0]  lo;
        lo = addr_lo & 3'((data_width / 8) - 1);
        case (size)
            3'd0:    m = 16'h0001;
            3'd1:    m = 16'h0003;
            3'd2:    m = 16'h000F;
            3'd3:    m = 16'h00FF;
            default: m = 16'h0000;
        endcase
        m = m << lo;
        return m[7:0];
    endfunction

endpackage

// File: rtl/peripheral_dbg_pu_riscv_ahb_slave_ram.sv
// Single-port scratch RAM with per-byte write enables and combinational read;
// swap for a technology macro with the same ports.
module peripheral_dbg_pu_riscv_ahb_slave_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                     biu_clk,
    input  logic                     we,
    input  logic [DATA_WIDTH/8-1:0]  be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge biu_clk) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (we && be[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/peripheral_dbg_pu_riscv_ahb_slave.sv
// AHB-Lite scratch-RAM slave for the debug unit. Optional wait states are
// compiled in with `define PERIPHERAL_DBG_AHB_SLAVE_WAIT_EN.
module peripheral_dbg_pu_riscv_ahb_slave
    import peripheral_dbg_pu_riscv_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int          NB     = DATA_WIDTH / 8;
    localparam int          AW_LO  = $clog2(NB);
    localparam int          AW_IDX = $clog2(MEM_DEPTH);
    localparam logic [63:0] RANGE  = 64'(MEM_DEPTH) * 64'(NB);

    slave_state_e          state_q;
    logic [ADDR_WIDTH-1:0] off_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
`ifdef PERIPHERAL_DBG_AHB_SLAVE_WAIT_EN
    logic [3:0]            cnt_q;
`endif

    // Address-phase decode
    logic                  accept;
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic                  range_err;
    logic                  size_err;
    logic                  align_err;
    logic                  acc_err;
    logic                  ready;

    assign accept     = HSEL & HREADY & HTRANS[1];
    assign off        = HADDR - BASE_ADDR;
    assign align_mask = ADDR_WIDTH'((32'd1 << HSIZE) - 32'd1);
    assign range_err  = (HADDR < BASE_ADDR) || (64'(off) >= RANGE);
    assign size_err   = int'(HSIZE) > AW_LO;
    assign align_err  = |(HADDR & align_mask);
    assign acc_err    = range_err | size_err | align_err;

    // ERR2 completes the error and may accept the next address phase like IDLE.
    assign ready     = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign HREADYOUT = ready;
    assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            off_q   <= '0;
            write_q <= 1'b0;
            size_q  <= 3'b000;
            valid_q <= 1'b0;
`ifdef PERIPHERAL_DBG_AHB_SLAVE_WAIT_EN
            cnt_q   <= 4'd0;
`endif
        end else if (ready) begin
            valid_q <= accept & ~acc_err;
            if (accept) begin
                off_q   <= off;
                write_q <= HWRITE;
                size_q  <= HSIZE;
            end
            if (accept && acc_err) begin
                state_q <= ST_ERR1;
`ifdef PERIPHERAL_DBG_AHB_SLAVE_WAIT_EN
            end else if (accept && (WAIT_STATES != 0)) begin
                state_q <= ST_WAIT;
                cnt_q   <= 4'(WAIT_STATES);
`endif
            end else begin
                state_q <= ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_ERR1: state_q <= ST_ERR2;
`ifdef PERIPHERAL_DBG_AHB_SLAVE_WAIT_EN
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_q <= ST_IDLE;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // RAM side: write lands on the edge that ends an OKAY write data phase.
    logic                  ram_we;
    logic [7:0]            be_full;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  rd_phase;

    assign be_full  = byte_en(size_q, off_q[2:0], DATA_WIDTH);
    assign ram_we   = valid_q & write_q & (state_q == ST_IDLE);
    assign rd_phase = valid_q & ~write_q;

    peripheral_dbg_pu_riscv_ahb_slave_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH)
    ) u_ram (
        .biu_clk (HCLK),
        .we      (ram_we),
        .be      (be_full[NB-1:0]),
        .addr    (off_q[AW_LO +: AW_IDX]),
        .wdata   (HWDATA),
        .rdata   (ram_rdata)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rdata_q <= '0;
        end else if (rd_phase) begin
            rdata_q <= ram_rdata;
        end
    end

    assign HRDATA = rd_phase ? ram_rdata : rdata_q;

    logic unused_sigs;
    assign unused_sigs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], off_q, be_full, 4'(WAIT_STATES)};

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_ahb_slave.sv
// Directed bench for the debug AHB scratch-RAM slave; wait-state checks
// follow `define PERIPHERAL_DBG_AHB_SLAVE_WAIT_EN.
module tb_peripheral_dbg_pu_riscv_ahb_slave;

`ifdef PERIPHERAL_DBG_AHB_SLAVE_WAIT_EN
    localparam int TB_WAITS = 3;
`else
    localparam int TB_WAITS = 0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;

    int errors = 0;
    int checks = 0;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    peripheral_dbg_pu_riscv_ahb_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_DEPTH   (256),
        .BASE_ADDR   (32'h0),
        .WAIT_STATES (TB_WAITS)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP)
    );

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HSIZE = 3'd2;
        HBURST = 3'd0; HPROT = 4'd0; HMASTLOCK = 1'b0;
    endtask

    // Single non-pipelined transfer; caller sits 1ns after a rising edge.
    task automatic do_xfer(input logic w, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic rsp, output int nw);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = a; HSIZE = sz;
        nw = 0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
        while (HREADYOUT !== 1'b1 && nw < 40) begin
            @(posedge HCLK); #1;
            nw++;
        end
        rd = HRDATA; rsp = HRESP;
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset();
        bus_idle();
        HWDATA = '0;
        HRESETn = 1'b0;
        #1;
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b resp=%b rdata=%h, want 1 0 00000000",
                     HREADYOUT, HRESP, HRDATA);
        end
        repeat (3) @(posedge HCLK);
        @(negedge HCLK); HRESETn = 1'b1;
        @(posedge HCLK); #1;
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b resp=%b, want 1 0", HREADYOUT, HRESP);
        end
    endtask

    task automatic test_back_to_back();
        int nw;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HWDATA = 32'hDEADBEEF;
        HWRITE = 1'b0;
        nw = 0;
        while (HREADYOUT !== 1'b1 && nw < 40) begin @(posedge HCLK); #1; nw++; end
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        nw = 0;
        while (HREADYOUT !== 1'b1 && nw < 40) begin @(posedge HCLK); #1; nw++; end
        checks++;
        if (HRDATA !== 32'hDEADBEEF || HRESP !== 1'b0 || nw != TB_WAITS) begin
            errors++;
            $display("FAIL b2b_read: got rdata=%h resp=%b waits=%0d, want deadbeef 0 %0d",
                     HRDATA, HRESP, nw, TB_WAITS);
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic rsp; int nw;
        do_xfer(1'b1, 32'h4, 3'd2, 32'h11223344, rd, rsp, nw);
        do_xfer(1'b1, 32'h6, 3'd0, 32'h00A50000, rd, rsp, nw);
        checks++;
        if (rsp !== 1'b0 || nw != TB_WAITS) begin
            errors++;
            $display("FAIL byte_write_resp: got resp=%b waits=%0d, want 0 %0d", rsp, nw, TB_WAITS);
        end
        do_xfer(1'b0, 32'h4, 3'd2, 32'h0, rd, rsp, nw);
        checks++;
        if (rd !== 32'h11A53344) begin
            errors++;
            $display("FAIL byte_lane_merge: got %h, want 11a53344", rd);
        end
    endtask

    task automatic test_error_range();
        logic [31:0] rd; logic rsp; int nw;
        do_xfer(1'b1, 32'h0, 3'd2, 32'h0BADF00D, rd, rsp, nw);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h400; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        checks++;
        if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin
            errors++;
            $display("FAIL err1_phase: got ready=%b resp=%b, want 0 1", HREADYOUT, HRESP);
        end
        @(posedge HCLK); #1;
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b1) begin
            errors++;
            $display("FAIL err2_phase: got ready=%b resp=%b, want 1 1", HREADYOUT, HRESP);
        end
        @(posedge HCLK); #1;
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            errors++;
            $display("FAIL err_recover: got ready=%b resp=%b, want 1 0", HREADYOUT, HRESP);
        end
        do_xfer(1'b1, 32'h400, 3'd2, 32'hCAFEF00D, rd, rsp, nw);
        checks++;
        if (rsp !== 1'b1 || nw != 1) begin
            errors++;
            $display("FAIL err_write_resp: got resp=%b waits=%0d, want 1 1", rsp, nw);
        end
        do_xfer(1'b0, 32'h0, 3'd2, 32'h0, rd, rsp, nw);
        checks++;
        if (rd !== 32'h0BADF00D || rsp !== 1'b0) begin
            errors++;
            $display("FAIL err_write_blocked: got %h resp=%b, want 0badf00d 0", rd, rsp);
        end
        do_xfer(1'b1, 32'h3FC, 3'd2, 32'h900DCAFE, rd, rsp, nw);
        do_xfer(1'b0, 32'h3FC, 3'd2, 32'h0, rd, rsp, nw);
        checks++;
        if (rd !== 32'h900DCAFE || rsp !== 1'b0) begin
            errors++;
            $display("FAIL top_word: got %h resp=%b, want 900dcafe 0", rd, rsp);
        end
        do_xfer(1'b0, 32'h0, 3'd3, 32'h0, rd, rsp, nw);
        checks++;
        if (rsp !== 1'b1) begin
            errors++;
            $display("FAIL size_err: got resp=%b, want 1", rsp);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic rsp; int nw;
        do_xfer(1'b1, 32'h8, 3'd2, 32'h55667788, rd, rsp, nw);
        do_xfer(1'b1, 32'h9, 3'd1, 32'hFFFFFFFF, rd, rsp, nw);
        checks++;
        if (rsp !== 1'b1 || nw != 1) begin
            errors++;
            $display("FAIL misalign_resp: got resp=%b waits=%0d, want 1 1", rsp, nw);
        end
        do_xfer(1'b1, 32'hA, 3'd1, 32'hABCD0000, rd, rsp, nw);
        checks++;
        if (rsp !== 1'b0) begin
            errors++;
            $display("FAIL aligned_after_err: got resp=%b, want 0", rsp);
        end
        do_xfer(1'b0, 32'h8, 3'd2, 32'h0, rd, rsp, nw);
        checks++;
        if (rd !== 32'hABCD7788) begin
            errors++;
            $display("FAIL halfword_merge: got %h, want abcd7788", rd);
        end
    endtask

    task automatic test_idle_busy();
        logic [31:0] rd; logic rsp; int nw;
        do_xfer(1'b1, 32'h20, 3'd2, 32'h12345678, rd, rsp, nw);
        HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 32'h20; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hFFFFFFFF;
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            errors++;
            $display("FAIL busy_okay: got ready=%b resp=%b, want 1 0", HREADYOUT, HRESP);
        end
        @(posedge HCLK); #1;
        do_xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, rsp, nw);
        checks++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("FAIL busy_no_write: got %h, want 12345678", rd);
        end
    endtask

    task automatic test_wait();
        int nw;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h4; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        nw = 0;
        while (HREADYOUT !== 1'b1 && nw < 40) begin @(posedge HCLK); #1; nw++; end
        checks++;
        if (nw != TB_WAITS || HRDATA !== 32'h11A53344 || HRESP !== 1'b0) begin
            errors++;
            $display("FAIL wait_read: got waits=%0d rdata=%h resp=%b, want %0d 11a53344 0",
                     nw, HRDATA, HRESP, TB_WAITS);
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic rsp; int nw;
        do_xfer(1'b1, 32'h10, 3'd2, 32'h01020304, rd, rsp, nw);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h10; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hFFFFFFFF;
        checks++;
        if (HREADYOUT !== (TB_WAITS == 0 ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL mid_ready_pre: got %b, want %b", HREADYOUT, (TB_WAITS == 0));
        end
        #2 HRESETn = 1'b0;
        #1;
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got ready=%b resp=%b rdata=%h, want 1 0 00000000",
                     HREADYOUT, HRESP, HRDATA);
        end
        @(posedge HCLK);
        @(negedge HCLK); HRESETn = 1'b1;
        @(posedge HCLK); #1;
        do_xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, rsp, nw);
        checks++;
        if (rd !== 32'h01020304) begin
            errors++;
            $display("FAIL mid_reset_discard: got %h, want 01020304", rd);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_error_range();
        test_misaligned();
        test_idle_busy();
        test_wait();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
